// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder: kind codes, opcodes and word field layout.
// Also holds the kind-to-opcode and word-packing helpers used by the encoder and decoder.
package instr_pkg;

  typedef enum logic [3:0] {
    K_LOAD  = 4'd0,
    K_STORE = 4'd1,
    K_JUMP  = 4'd2,
    K_BRZ   = 4'd3,
    K_CTYPE = 4'd4,
    K_ADDI  = 4'd5,
    K_SUBI  = 4'd6,
    K_ANDI  = 4'd7,
    K_ORI   = 4'd8
  } kind_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0001;
  localparam logic [3:0] OP_JUMP  = 4'b0010;
  localparam logic [3:0] OP_BRZ   = 4'b0100;
  localparam logic [3:0] OP_CTYPE = 4'b1000;
  localparam logic [3:0] OP_ADDI  = 4'b1100;
  localparam logic [3:0] OP_SUBI  = 4'b1101;
  localparam logic [3:0] OP_ANDI  = 4'b1110;
  localparam logic [3:0] OP_ORI   = 4'b1111;

  localparam int WORD_W  = 16;
  localparam int OP_LSB  = 12;
  localparam int OP_W    = 4;
  localparam int RS_LSB  = 10;
  localparam int RT_LSB  = 8;
  localparam int REG_W   = 2;
  localparam int IMM_LSB = 0;
  localparam int IMM_W   = 8;

  typedef struct packed {
    logic            legal;
    logic [OP_W-1:0] op;
  } op_t;

  function automatic op_t kind_to_op(input logic [3:0] kind);
    op_t r;
    r.legal = 1'b1;
    r.op    = OP_LOAD;
    case (kind)
      K_LOAD:  r.op = OP_LOAD;
      K_STORE: r.op = OP_STORE;
      K_JUMP:  r.op = OP_JUMP;
      K_BRZ:   r.op = OP_BRZ;
      K_CTYPE: r.op = OP_CTYPE;
      K_ADDI:  r.op = OP_ADDI;
      K_SUBI:  r.op = OP_SUBI;
      K_ANDI:  r.op = OP_ANDI;
      K_ORI:   r.op = OP_ORI;
      default: r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [OP_W-1:0]  op,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic [IMM_W-1:0] imm
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[OP_LSB  +: OP_W]  = op;
    w[RS_LSB  +: REG_W] = rs;
    w[RT_LSB  +: REG_W] = rt;
    w[IMM_LSB +: IMM_W] = imm;
    return w;
  endfunction

endpackage

// File: rtl/instr_fifo.sv
// Power-of-two FIFO for encoded words; push while full is accepted only alongside a pop.
// flush empties the queue in one cycle without touching storage.
module instr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes operation requests into 16-bit words and streams them to instruction memory.
// Optional build macro INSTR_ENC_CHECKSUM_EN adds a running XOR checksum output.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_kind,
  input  logic [1:0]        req_rs,
  input  logic [1:0]        req_rt,
  input  logic [7:0]        req_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err_illegal,
  output logic              busy,
  output logic              full_stop,
  output logic [ADDR_W:0]   word_count
`ifdef INSTR_ENC_CHECKSUM_EN
  ,
  output logic [15:0]       checksum
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  state_e            state, state_nx;
  op_t               dec;
  logic              accept, wr_done, last_wr, drained, end_req;
  logic              enc_vld;
  logic [WORD_W-1:0] enc_word;
  logic [ADDR_W-1:0] addr;
  logic              f_empty, f_full;
  logic [CW-1:0]     f_cnt;

  assign dec      = kind_to_op(req_kind);
  assign accept   = req_valid && req_ready;
  assign wr_done  = mem_we && mem_ready;
  assign last_wr  = wr_done && (&addr);
  assign drained  = f_empty && !enc_vld;
  assign mem_addr = addr;

  // The staged word counts against capacity so the FIFO can never overflow.
  instr_fifo #(.DEPTH(DEPTH), .W(WORD_W)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (last_wr),
    .push  (enc_vld && !last_wr),
    .din   (enc_word),
    .pop   (wr_done),
    .dout  (mem_wdata),
    .empty (f_empty),
    .full  (f_full),
    .count (f_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start) state_nx = S_RUN;
      S_RUN: begin
        if (last_wr)
          state_nx = S_DONE;
        else if ((end_req || start) && drained && !accept)
          state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE);
    mem_we    = (state == S_RUN) && !f_empty;
    req_ready = (state == S_RUN) && !full_stop && !f_full &&
                ((f_cnt + CW'(enc_vld)) < CW'(DEPTH));
  end

  // start while running only marks end-of-session; the drain completes it.
  always_ff @(posedge clk) begin
    if (rst)                 end_req <= 1'b0;
    else if (state == S_RUN) begin
      if (start) end_req <= 1'b1;
    end else                 end_req <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_vld     <= 1'b0;
      enc_word    <= '0;
      err_illegal <= 1'b0;
      addr        <= '0;
      word_count  <= '0;
      full_stop   <= 1'b0;
    end else begin
      err_illegal <= accept && !dec.legal;
      enc_vld     <= accept && dec.legal && !last_wr;
      if (accept) enc_word <= pack_word(dec.op, req_rs, req_rt, req_imm);
      if (state == S_IDLE && start) begin
        addr       <= base_addr;
        word_count <= '0;
        full_stop  <= 1'b0;
      end else if (wr_done) begin
        word_count <= word_count + (ADDR_W+1)'(1);
        if (&addr) full_stop <= 1'b1;
        else       addr      <= addr + ADDR_W'(1);
      end
    end
  end

`ifdef INSTR_ENC_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst)                        checksum <= '0;
    else if (state == S_IDLE && start) checksum <= '0;
    else if (wr_done)               checksum <= checksum ^ mem_wdata;
  end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder with a queue-based scoreboard of expected memory writes.
// Define INSTR_ENC_CHECKSUM_EN on both DUT and bench to cover the checksum output.
module tb_instr_encoder;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst, start, req_valid, req_ready;
  logic [ADDR_W-1:0] base_addr, mem_addr;
  logic [3:0]        req_kind;
  logic [1:0]        req_rs, req_rt;
  logic [7:0]        req_imm;
  logic              mem_we, mem_ready, err_illegal, busy, full_stop;
  logic [15:0]       mem_wdata;
  logic [ADDR_W:0]   word_count;
`ifdef INSTR_ENC_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  logic mem_rdy_d, rnd_rdy, rnd_bit;
  assign mem_ready = rnd_rdy ? rnd_bit : mem_rdy_d;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .err_illegal(err_illegal), .busy(busy), .full_stop(full_stop), .word_count(word_count)
`ifdef INSTR_ENC_CHECKSUM_EN
    , .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: opcode per legal kind, word = {opcode, rs, rt, imm}.
  logic [3:0] op_tab [9] = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'hC, 4'hD, 4'hE, 4'hF};

  logic [15:0]       q [$];
  logic [15:0]       wr_log [$];
  logic [ADDR_W-1:0] exp_addr = '0;
  int                exp_cnt = 0;
  logic              exp_err = 1'b0, exp_full = 1'b0;
  logic [15:0]       exp_sum = '0;
  logic              hold_v = 1'b0;
  logic [24:0]       hold_val;
  int                nwr = 0, err_seen = 0;
  logic [15:0]       last_w;
  logic [ADDR_W-1:0] last_a;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      exp_err = 0; exp_cnt = 0; exp_full = 0; exp_addr = '0; exp_sum = '0; hold_v = 0;
    end else begin
      chk("err_illegal", 32'(err_illegal), 32'(exp_err));
      chk("word_count", 32'(word_count), 32'(exp_cnt));
      chk("full_stop", 32'(full_stop), 32'(exp_full));
      if (err_illegal) err_seen++;
      if (hold_v) chk("stall_hold", 32'({mem_we, mem_addr, mem_wdata}), 32'(hold_val));
      exp_err = 0;
      if (req_valid && req_ready) begin
        chk("ready_room", 32'(q.size() < DEPTH), 32'd1);
        if (req_kind <= 4'd8) q.push_back({op_tab[req_kind], req_rs, req_rt, req_imm});
        else exp_err = 1;
      end
      hold_v   = mem_we && !mem_ready;
      hold_val = {mem_we, mem_addr, mem_wdata};
      if (mem_we && mem_ready) begin
        if (q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
        else chk("wdata", 32'(mem_wdata), 32'(q.pop_front()));
        chk("waddr", 32'(mem_addr), 32'(exp_addr));
        wr_log.push_back(mem_wdata);
        last_w = mem_wdata; last_a = mem_addr;
        nwr++; exp_cnt++;
        exp_sum ^= mem_wdata;
        if (exp_addr == '1) begin exp_full = 1; q.delete(); end
        else exp_addr++;
      end
    end
  end

  task automatic start_session(input logic [ADDR_W-1:0] b);
    start = 1; base_addr = b;
    @(posedge clk); #1;
    start = 0;
    exp_addr = b; exp_cnt = 0; exp_full = 0; exp_sum = '0; q.delete();
  endtask

  task automatic send(input logic [3:0] k, input logic [1:0] rs, input logic [1:0] rt,
                      input logic [7:0] imm, output bit ok);
    req_kind = k; req_rs = rs; req_rt = rt; req_imm = imm; req_valid = 1; ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && (q.size() != 0 || mem_we); i++) begin
      @(posedge clk); #1;
    end
    chk("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle", 32'(busy), 32'd0);
  endtask

  task automatic end_session();
    rnd_rdy = 0; mem_rdy_d = 1;
    wait_drain();
    if (busy) begin
      start = 1; @(posedge clk); #1; start = 0;
    end
    wait_idle();
  endtask

  task automatic chk_zero(input string pfx);
    chk({pfx, "_mem_we"}, 32'(mem_we), 0);
    chk({pfx, "_req_ready"}, 32'(req_ready), 0);
    chk({pfx, "_err"}, 32'(err_illegal), 0);
    chk({pfx, "_full_stop"}, 32'(full_stop), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_count"}, 32'(word_count), 0);
    chk({pfx, "_addr"}, 32'(mem_addr), 0);
`ifdef INSTR_ENC_CHECKSUM_EN
    chk({pfx, "_checksum"}, 32'(checksum), 0);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n0, c0, e0, acc, idx, base_i;
    rst = 1; start = 0; base_addr = '0; req_valid = 0; req_kind = '0;
    req_rs = '0; req_rt = '0; req_imm = '0; mem_rdy_d = 1; rnd_rdy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1; rst = 0;

    // Single Addi at base 0x10
    start_session(8'h10);
    send(4'd5, 2'd1, 2'd2, 8'h05, ok);
    wait_drain();
    chk("addi_count", 32'(word_count), 1);
    chk("addi_data", 32'(last_w), 32'hC605);
    chk("addi_addr", 32'(last_a), 32'h10);
    end_session();

    // All legal kinds, zero fields
    start_session(8'h20);
    base_i = wr_log.size();
    for (int k = 0; k < 9; k++) send(4'(k), 2'd0, 2'd0, 8'd0, ok);
    wait_drain();
    chk("kinds_written", 32'(wr_log.size() - base_i), 9);
    for (int k = 0; k < 9 && base_i + k < wr_log.size(); k++)
      chk("kind_nibble", 32'(wr_log[base_i + k][15:12]), 32'(op_tab[k]));
    end_session();

    // Illegal kind
    start_session(8'h30);
    n0 = nwr; c0 = exp_cnt; e0 = err_seen;
    send(4'd9, 2'd3, 2'd1, 8'hAA, ok);
    repeat (5) begin @(posedge clk); #1; end
    chk("illegal_nowrite", 32'(nwr - n0), 0);
    chk("illegal_count", 32'(word_count), 32'(c0));
    chk("illegal_pulses", 32'(err_seen - e0), 1);
    end_session();

    // Stalled memory while 6 requests are offered
    start_session(8'h40);
    mem_rdy_d = 0; acc = 0; idx = 0;
    req_valid = 1; req_kind = 4'd0; req_rs = 2'd1; req_rt = 2'd0; req_imm = 8'd0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (req_valid && req_ready) begin acc++; idx++; end
      @(posedge clk); #1;
      req_valid = (idx < 6);
      req_kind = 4'(idx % 9); req_imm = 8'(idx * 17);
    end
    req_valid = 0;
    chk("stall_accepted", 32'(acc), 4);
    chk("stall_mem_we", 32'(mem_we), 1);
    mem_rdy_d = 1;
    for (int r = idx; r < 6; r++) send(4'(r % 9), 2'd1, 2'd0, 8'(r * 17), ok);
    wait_drain();
    chk("stall_total", 32'(word_count), 6);
    end_session();

    // Address exhaustion at 0xFE
    start_session(8'hFE);
    n0 = nwr;
    for (int r = 0; r < 3; r++) send(4'd1, 2'd2, 2'd3, 8'(r), ok);
    wait_idle();
    chk("top_full_stop", 32'(full_stop), 1);
    chk("top_count", 32'(word_count), 2);
    chk("top_writes", 32'(nwr - n0), 2);

    // Random sessions with random memory back-pressure
    for (int s = 0; s < 8; s++) begin
      start_session(($urandom_range(0, 2) == 0) ? 8'($urandom_range(240, 255))
                                                : 8'($urandom_range(0, 200)));
      rnd_rdy = 1;
      for (int r = 0; r < int'($urandom_range(5, 20)); r++) begin
        if (full_stop || !busy) break;
        send(4'($urandom_range(0, 15)), 2'($urandom), 2'($urandom), 8'($urandom), ok);
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
      if (full_stop) begin rnd_rdy = 0; mem_rdy_d = 1; wait_idle(); end
      else end_session();
    end

    // Reset during a stalled write
    mem_rdy_d = 1;
    start_session(8'h50);
    send(4'd5, 2'd1, 2'd2, 8'h05, ok);
    send(4'd0, 2'd0, 2'd0, 8'h00, ok);
    wait_drain();
`ifdef INSTR_ENC_CHECKSUM_EN
    chk("checksum_model", 32'(checksum), 32'(exp_sum));
    chk("checksum_value", 32'(checksum), 32'hC605);
`endif
    mem_rdy_d = 0;
    send(4'd3, 2'd1, 2'd1, 8'h7F, ok);
    for (int i = 0; i < 20 && !mem_we; i++) begin @(posedge clk); #1; end
    chk("pre_rst_stall", 32'(mem_we), 1);
    rst = 1;
    @(posedge clk); @(negedge clk);
    chk_zero("midrst");
    @(posedge clk); #1; rst = 0; mem_rdy_d = 1;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_busy", 32'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of encoded-word FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning the instruction-memory address width.
REQ-003 Port clk, input, 1 bit: the single clock. Reset is synchronous and active-high.
REQ-004 Port rst, input, 1 bit: the synchronous, active-high reset.
REQ-005 Port start, input, 1: one-cycle pulse that begins a load session at base_addr.
REQ-006 Port base_addr, input, ADDR_W: first memory address of the session.
REQ-007 Port req_valid, input, 1: an operation request is present.
REQ-008 Port req_ready, output, 1: a request is accepted this cycle when req_valid is also high.
REQ-009 Port req_kind, input, 4: operation kind (0 Load, 1 Store, 2 Jump, 3 BranchZ, 4 C-type, 5 Addi, 6 Subi, 7 Andi, 8 Ori; 9-15 illegal).
REQ-010 Port req_rs / req_rt, input, 2 each: register fields.
REQ-011 Port req_imm, input, 8: immediate, offset, or function field.
REQ-012 Port mem_we, output, 1: write strobe to instruction memory.
REQ-013 Port mem_addr, output, ADDR_W: write address.
REQ-014 Port mem_wdata, output, 16: encoded instruction word.
REQ-015 Port mem_ready, input, 1: memory accepts the write this cycle.
REQ-016 Port err_illegal, output, 1: one-cycle pulse when an illegal kind is accepted.
REQ-017 Port busy, output, 1: high when the session state is not IDLE.
REQ-018 Port full_stop, output, 1: high when the address space is exhausted.
REQ-019 Port word_count, output, ADDR_W+1: number of words written in the current session.

Function
REQ-020 Word format SHALL be [15:12] opcode, [11:10] rs, [9:8] rt, [7:0] imm.
REQ-021 Kind-to-opcode mapping SHALL be: Load 0000, Store 0001, Jump 0010, BranchZ 0100, C-type 1000, Addi 1100, Subi 1101, Andi 1110, Ori 1111.
REQ-022 An illegal kind SHALL be dropped, not enqueued, and SHALL pulse err_illegal in the cycle after acceptance.
REQ-023 Encoding SHALL be registered: an accepted word enters the FIFO one cycle after the handshake.
REQ-024 req_ready SHALL be high only when state is RUN, the FIFO is not full, and full_stop is low.
REQ-025 The FSM SHALL have states IDLE, RUN, and DONE; rst leads to IDLE.
REQ-026 In IDLE, start SHALL load the address counter with base_addr, clear word_count, and move to RUN.
REQ-027 In RUN, if the FIFO is non-empty, mem_we SHALL equal 1 with the head word; a write completes when mem_we and mem_ready are both high, which pops the FIFO, increments the address and word_count.
REQ-028 mem_addr, mem_wdata, and mem_we SHALL hold stable while mem_ready is low.
REQ-029 If a write completes to the all-ones address, full_stop SHALL set, the counter SHALL NOT wrap, and the FSM SHALL go to DONE; FIFO contents are discarded.
REQ-030 In RUN, start SHALL move the FSM to DONE once the FIFO has drained (an end-of-session marker); DONE returns to IDLE the next cycle.
REQ-031 A simultaneous enqueue and pop SHALL keep the occupancy unchanged, including when the FIFO is full.
REQ-032 start in DONE SHALL be ignored.

Reset
REQ-033 rst SHALL force IDLE, an empty FIFO, address 0, word_count 0, and mem_we, req_ready, err_illegal, full_stop, and busy all at 0, including mid-write.

Configuration
REQ-034 With INSTR_ENC_CHECKSUM_EN defined, an output port checksum[15:0] SHALL be present, holding the XOR of all words written this session and cleared on start or rst.
REQ-035 Without INSTR_ENC_CHECKSUM_EN, the port and its logic SHALL be absent, with no other behaviour change.

Structure
REQ-036 A shared package instr_pkg SHALL hold the kind enum, the opcode constants, and the field position constants; the decoder uses the same package.
REQ-037 The FIFO SHALL be a sub-module, instr_fifo (parameter DEPTH, width 16).

Verification
REQ-038 Case: base 0x10, enqueue Addi rs=1 rt=2 imm=0x05 with mem_ready=1. Expected: one write at 0x10 with data 0xC605, and word_count=1.
REQ-039 Case: all 9 legal kinds with rs=rt=0 and imm=0. Expected: upper nibbles 0,1,2,4,8,C,D,E,F at consecutive addresses.
REQ-040 Case: req_kind=9. Expected: err_illegal pulses once, with no write and no count change.
REQ-041 Case: mem_ready=0 for 10 cycles while 6 requests are offered. Expected: req_ready drops after 4 are accepted, outputs stay stable, and all words are later written in order.
REQ-042 Case: base 0xFE with 3 requests. Expected: writes at 0xFE and 0xFF, then full_stop=1, DONE, and the third word is never written.
REQ-043 Case: rst asserted during a stalled write. Expected: all outputs 0 on the next cycle; with the macro defined, checksum equals the XOR of written words (0xC605 ^ 0x0000 = 0xC605).
